// File: rtl/rx_sample_scheduler.sv
// rx_sample_scheduler
//   Collects one I/Q sample per enabled receiver channel into a one-deep
//   buffer per channel. Once every enabled channel holds a pending sample,
//   it emits the set on a valid/ready stream in ascending channel order.
//   A strobe that lands on a still-pending sample overwrites it and is
//   counted as an overrun.
//
// Ports
//   clock, reset_n        system clock, asynchronous active-low reset
//   rx_enable[NRX]        channel enable mask, latched while idle
//   rx_strobe[NRX]        per-channel sample-valid pulse
//   rx_I/rx_Q[NRX*DW]     channel k sample in bits [k*DW +: DW]
//   out_valid/out_ready   output handshake
//   out_data[2*DW]        {I, Q} of the presented channel
//   out_chan[2]           index of the presented channel
//   out_last              presented channel is the last of the set
//   overrun, overrun_count  sticky flag and saturating overwrite count
//   overrun_clr           synchronous clear of the overrun status
module rx_sample_scheduler #(
    parameter int NRX = 2,
    parameter int DW  = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NRX-1:0]    rx_enable,
    input  logic [NRX-1:0]    rx_strobe,
    input  logic [NRX*DW-1:0] rx_I,
    input  logic [NRX*DW-1:0] rx_Q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*DW-1:0]   out_data,
    output logic [1:0]        out_chan,
    output logic              out_last,
    output logic              overrun,
    output logic [15:0]       overrun_count,
    input  logic              overrun_clr
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [NRX-1:0]         mask_q;
    logic [NRX-1:0]         pending_q;
    logic [NRX-1:0][DW-1:0] buf_i_q, buf_q_q;

    logic [NRX-1:0]  strobe_acc, handoff_vec, overwrite_vec;
    logic            all_pending, handoff, launch, load_en, mask_load;
    logic [1:0]      first_chan, high_chan, next_chan, load_chan;
    logic [2*DW-1:0] load_data;
    logic [2:0]      overwrite_num;
    logic [16:0]     count_sum;

    // Strobes on channels outside the latched mask are dropped entirely.
    assign strobe_acc    = rx_strobe & mask_q;
    assign all_pending   = (mask_q != '0) && ((pending_q & mask_q) == mask_q);
    assign handoff       = (state_q == SEND) && out_valid && out_ready;
    assign launch        = (state_q == IDLE) && all_pending;
    assign overwrite_vec = strobe_acc & pending_q & ~handoff_vec;

    // The mask is frozen from the launch edge until the last handoff, so the
    // set in flight always uses the mask it was launched with. The final
    // handoff edge already picks up the new mask.
    assign mask_load = ((state_q == IDLE) && !launch) || (handoff && out_last);
    assign load_en   = launch || (handoff && !out_last);
    assign load_chan = launch ? first_chan : next_chan;

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin : chan_search
        first_chan  = '0;
        high_chan   = '0;
        next_chan   = '0;
        handoff_vec = '0;
        for (int k = NRX - 1; k >= 0; k--) begin
            if (mask_q[k]) first_chan = 2'(k);
            if (mask_q[k] && (2'(k) > out_chan)) next_chan = 2'(k);
        end
        for (int k = 0; k < NRX; k++) begin
            if (mask_q[k]) high_chan = 2'(k);
            if (handoff && (out_chan == 2'(k))) handoff_vec[k] = 1'b1;
        end
    end

    // A strobe arriving on the very edge a channel is loaded into the output
    // register is forwarded, so the newest sample is always the one emitted.
    always_comb begin : load_mux
        load_data = '0;
        for (int k = 0; k < NRX; k++) begin
            if (load_chan == 2'(k)) begin
                load_data = strobe_acc[k] ? {rx_I[k*DW +: DW], rx_Q[k*DW +: DW]}
                                          : {buf_i_q[k], buf_q_q[k]};
            end
        end
    end

    always_comb begin : overwrite_sum
        overwrite_num = '0;
        for (int k = 0; k < NRX; k++) begin
            overwrite_num = overwrite_num + 3'(overwrite_vec[k]);
        end
        count_sum = {1'b0, overrun_count} + 17'(overwrite_num);
    end

    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            IDLE: if (launch) state_d = SEND;
            SEND: if (handoff && out_last) state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin : core_regs
        if (!reset_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            pending_q <= '0;
            // NOTE: the sample buffers are small register arrays with a
            // defined reset value, so they are reset with everything else.
            buf_i_q   <= '0;
            buf_q_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            out_last  <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= (state_d == SEND);
            if (mask_load) mask_q <= rx_enable;
            // A handoff clears pending unless a fresh strobe refills it;
            // channels dropped from the mask lose any stale pending bit.
            pending_q <= strobe_acc | (pending_q & mask_q & ~handoff_vec);
            for (int k = 0; k < NRX; k++) begin
                if (strobe_acc[k]) begin
                    buf_i_q[k] <= rx_I[k*DW +: DW];
                    buf_q_q[k] <= rx_Q[k*DW +: DW];
                end
            end
            if (load_en) begin
                out_data <= load_data;
                out_chan <= load_chan;
                out_last <= (load_chan == high_chan);
            end
        end
    end

    // Clear wins over a same-cycle overwrite.
    always_ff @(posedge clock or negedge reset_n) begin : overrun_regs
        if (!reset_n) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (overrun_clr) begin
            overrun       <= 1'b0;
            overrun_count <= '0;
        end else if (overwrite_vec != '0) begin
            overrun       <= 1'b1;
            overrun_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
        end
    end

endmodule

// File: tb/tb_rx_sample_scheduler.sv
// Self-checking bench for rx_sample_scheduler (NRX=2, DW=24).
// A queue-based model predicts the output stream and overrun status every
// cycle; directed sections pin the model with hand-computed literals.
module tb_rx_sample_scheduler;

    localparam int NRX = 2;
    localparam int DW  = 24;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NRX-1:0]    rx_enable;
    logic [NRX-1:0]    rx_strobe;
    logic [NRX*DW-1:0] rx_I;
    logic [NRX*DW-1:0] rx_Q;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_data;
    logic [1:0]        out_chan;
    logic              out_last;
    logic              overrun;
    logic [15:0]       overrun_count;
    logic              overrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    rx_sample_scheduler #(.NRX(NRX), .DW(DW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rx_enable     (rx_enable),
        .rx_strobe     (rx_strobe),
        .rx_I          (rx_I),
        .rx_Q          (rx_Q),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_last      (out_last),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .overrun_clr   (overrun_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [NRX-1:0] m_mask = '0;
    bit             m_pend [NRX];
    logic [DW-1:0]  m_bi   [NRX];
    logic [DW-1:0]  m_bq   [NRX];
    int             m_q[$];          // channels of the set still to emit
    bit             m_send = 1'b0;
    logic [2*DW-1:0] m_data = '0;
    int             m_chan = 0;
    bit             m_last = 1'b0;
    bit             m_ovr  = 1'b0;
    int             m_cnt  = 0;

    task automatic model_reset();
        m_mask = '0;
        for (int k = 0; k < NRX; k++) begin
            m_pend[k] = 1'b0; m_bi[k] = '0; m_bq[k] = '0;
        end
        m_q.delete();
        m_send = 1'b0; m_data = '0; m_chan = 0; m_last = 1'b0;
        m_ovr = 1'b0; m_cnt = 0;
    endtask

    task automatic model_present();
        m_chan = m_q[0];
        m_data = {m_bi[m_q[0]], m_bq[m_q[0]]};
        m_last = (m_q.size() == 1);
    endtask

    task automatic model_step();
        bit old_send, hand, launch, all_p, last_hand;
        int hk, ovw;
        old_send  = m_send;
        hand      = m_send && out_ready;
        hk        = hand ? m_q[0] : -1;
        last_hand = hand && (m_q.size() == 1);
        ovw   = 0;
        all_p = 1'b1;
        for (int k = 0; k < NRX; k++) begin
            if (rx_strobe[k] && m_mask[k] && m_pend[k] && k != hk) ovw++;
            if (m_mask[k] && !m_pend[k]) all_p = 1'b0;
        end
        launch = !old_send && (m_mask != '0) && all_p;
        for (int k = 0; k < NRX; k++) begin
            if (rx_strobe[k] && m_mask[k]) begin
                m_bi[k] = rx_I[k*DW +: DW];
                m_bq[k] = rx_Q[k*DW +: DW];
                m_pend[k] = 1'b1;
            end else if (k == hk || !m_mask[k]) begin
                m_pend[k] = 1'b0;
            end
        end
        if (launch) begin
            m_q.delete();
            for (int k = 0; k < NRX; k++) if (m_mask[k]) m_q.push_back(k);
            m_send = 1'b1;
            model_present();
        end else if (hand) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_send = 1'b0;
            else model_present();
        end
        if ((!old_send && !launch) || last_hand) m_mask = rx_enable;
        if (overrun_clr) begin
            m_ovr = 1'b0; m_cnt = 0;
        end else if (ovw > 0) begin
            m_ovr = 1'b1;
            m_cnt = (m_cnt + ovw > 16'hFFFF) ? 16'hFFFF : m_cnt + ovw;
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    // Cycle-by-cycle compare, away from the active edge.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            check("cyc_valid", 64'(out_valid), 64'(m_send));
            if (m_send) begin
                check("cyc_data", 64'(out_data), 64'(m_data));
                check("cyc_chan", 64'(out_chan), 64'(m_chan));
                check("cyc_last", 64'(out_last), 64'(m_last));
            end
            check("cyc_overrun", 64'(overrun), 64'(m_ovr));
            check("cyc_count", 64'(overrun_count), 64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asserts reset just after an edge, checks the reset state, and releases
    // it mid-cycle.
    task automatic reset_pulse();
        reset_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_chan", 64'(out_chan), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_count", 64'(overrun_count), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic strobe_both(input logic [DW-1:0] i0, input logic [DW-1:0] q0,
                               input logic [DW-1:0] i1, input logic [DW-1:0] q1);
        rx_I = {i1, i0};
        rx_Q = {q1, q0};
        rx_strobe = 2'b11;
        tick();
        rx_strobe = 2'b00;
    endtask

    initial begin
        reset_n = 1'b0; rx_enable = '0; rx_strobe = '0; rx_I = '0; rx_Q = '0;
        out_ready = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_pulse();

        // Basic two-channel set, 1-cycle latency.
        rx_enable = 2'b11; out_ready = 1'b1;
        tick(); tick();
        strobe_both(24'h000001, 24'h000002, 24'h000003, 24'h000004);
        check("a_idle_before", 64'(out_valid), 64'd0);
        tick();
        check("a_valid0", 64'(out_valid), 64'd1);
        check("a_data0", 64'(out_data), 64'h000001000002);
        check("a_chan0", 64'(out_chan), 64'd0);
        check("a_last0", 64'(out_last), 64'd0);
        tick();
        check("a_data1", 64'(out_data), 64'h000003000004);
        check("a_chan1", 64'(out_chan), 64'd1);
        check("a_last1", 64'(out_last), 64'd1);
        tick();
        check("a_idle_after", 64'(out_valid), 64'd0);

        // Mask 2'b10: chan 0 strobes are ignored.
        tick(); reset_pulse();
        rx_enable = 2'b10;
        tick(); tick();
        rx_I = {24'h0, 24'hDEAD01}; rx_Q = {24'h0, 24'hBEEF01};
        rx_strobe = 2'b01; tick();
        rx_strobe = 2'b01; tick();
        rx_strobe = 2'b00; tick(); tick();
        check("b_no_valid", 64'(out_valid), 64'd0);
        check("b_no_overrun", 64'(overrun), 64'd0);
        rx_I = {24'hAAAAAA, 24'h0}; rx_Q = {24'h555555, 24'h0};
        rx_strobe = 2'b10; tick();
        rx_strobe = 2'b00; tick();
        check("b_valid", 64'(out_valid), 64'd1);
        check("b_chan", 64'(out_chan), 64'd1);
        check("b_last", 64'(out_last), 64'd1);
        check("b_data", 64'(out_data), 64'hAAAAAA555555);
        tick();
        check("b_idle", 64'(out_valid), 64'd0);

        // Back-pressure for 5 cycles with an overwrite on chan 1.
        tick(); reset_pulse();
        rx_enable = 2'b11; out_ready = 1'b0;
        tick(); tick();
        strobe_both(24'h000010, 24'h000020, 24'h000030, 24'h000040);
        tick();
        check("c_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                rx_I = {24'h000031, 24'h0}; rx_Q = {24'h000041, 24'h0};
                rx_strobe = 2'b10;
            end
            tick();
            rx_strobe = 2'b00;
            check("c_hold_valid", 64'(out_valid), 64'd1);
            check("c_hold_data", 64'(out_data), 64'h000010000020);
            check("c_hold_chan", 64'(out_chan), 64'd0);
            check("c_hold_last", 64'(out_last), 64'd0);
        end
        check("c_overrun", 64'(overrun), 64'd1);
        check("c_count", 64'(overrun_count), 64'd1);
        out_ready = 1'b1;
        tick();
        check("c_data1", 64'(out_data), 64'h000031000041);
        check("c_chan1", 64'(out_chan), 64'd1);
        check("c_last1", 64'(out_last), 64'd1);
        tick();
        check("c_idle", 64'(out_valid), 64'd0);

        // Saturation, then clear racing an overwrite.
        tick(); reset_pulse();
        rx_enable = 2'b11;
        tick(); tick();
        rx_I = {24'h0, 24'h123456}; rx_Q = {24'h0, 24'h654321};
        rx_strobe = 2'b01;
        repeat (65538) tick();
        check("d_count_sat", 64'(overrun_count), 64'hFFFF);
        check("d_overrun_set", 64'(overrun), 64'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0; rx_strobe = 2'b00;
        check("d_count_clr", 64'(overrun_count), 64'd0);
        check("d_overrun_clr", 64'(overrun), 64'd0);

        // Reset mid-SEND after chan 0 handoff; strobes on first edge ignored.
        tick(); reset_pulse();
        rx_enable = 2'b11; out_ready = 1'b1;
        tick(); tick();
        strobe_both(24'h000111, 24'h000222, 24'h000333, 24'h000444);
        tick();
        tick();
        check("e_chan1_shown", 64'(out_chan), 64'd1);
        reset_n = 1'b0;
        #1;
        check("e_rst_valid", 64'(out_valid), 64'd0);
        check("e_rst_data", 64'(out_data), 64'd0);
        check("e_rst_chan", 64'(out_chan), 64'd0);
        check("e_rst_last", 64'(out_last), 64'd0);
        rx_I = {24'h999999, 24'h888888}; rx_Q = {24'h777777, 24'h666666};
        rx_strobe = 2'b11;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        rx_strobe = 2'b00;
        tick(); tick();
        check("e_first_edge_ignored", 64'(out_valid), 64'd0);
        strobe_both(24'h000515, 24'h000626, 24'h000737, 24'h000848);
        tick();
        check("e_new_data0", 64'(out_data), 64'h000515000626);
        check("e_new_chan0", 64'(out_chan), 64'd0);
        tick();
        check("e_new_data1", 64'(out_data), 64'h000737000848);
        check("e_new_last1", 64'(out_last), 64'd1);
        tick();

        // Mask change during SEND takes effect on the following set.
        tick(); reset_pulse();
        rx_enable = 2'b11; out_ready = 1'b0;
        tick(); tick();
        strobe_both(24'h0000A0, 24'h0000B0, 24'h0000C0, 24'h0000D0);
        tick();
        rx_enable = 2'b01;
        tick(); tick();
        out_ready = 1'b1;
        tick();
        check("f_chan1", 64'(out_chan), 64'd1);
        check("f_last1", 64'(out_last), 64'd1);
        check("f_data1", 64'(out_data), 64'h0000C00000D0);
        tick();
        check("f_idle", 64'(out_valid), 64'd0);
        rx_I = {24'h0, 24'h0000E0}; rx_Q = {24'h0, 24'h0000F0};
        rx_strobe = 2'b01; tick();
        rx_strobe = 2'b00; tick();
        check("f_only_chan0", 64'(out_chan), 64'd0);
        check("f_only_last", 64'(out_last), 64'd1);
        check("f_only_data", 64'(out_data), 64'h0000E00000F0);
        tick();
        check("f_only_idle", 64'(out_valid), 64'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 39) == 0) rx_enable = 2'($urandom_range(0, 3));
            rx_strobe[0] = ($urandom_range(0, 2) == 0);
            rx_strobe[1] = ($urandom_range(0, 2) == 0);
            rx_I = {24'($urandom), 24'($urandom)};
            rx_Q = {24'($urandom), 24'($urandom)};
            out_ready   = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rx_strobe = '0;
                reset_pulse();
            end
            tick();
        end
        rx_strobe = '0; overrun_clr = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_sample_scheduler.md
RX_SAMPLE_SCHEDULER -- requirements
Module: rx_sample_scheduler

Interface
REQ-001 SHALL have parameter NRX, default 2, legal 1..4: number of receiver (DDC) channels served.
REQ-002 SHALL have parameter DW, default 24: width of each I and Q sample.
REQ-003 SHALL have port clock  input  1: single system clock (61.44 MHz); all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port rx_enable  input  NRX: per-channel enable mask, sampled only in IDLE.
REQ-006 SHALL have port rx_strobe  input  NRX: per-channel one-cycle sample-valid from each receiver.
REQ-007 SHALL have port rx_I  input  NRX*DW: channel k I sample in bits [k*DW +: DW].
REQ-008 SHALL have port rx_Q  input  NRX*DW: channel k Q sample, same packing.
REQ-009 SHALL have port out_valid  output  1: out_data/out_chan/out_last valid.
REQ-010 SHALL have port out_ready  input  1: downstream accepts when out_valid and out_ready high.
REQ-011 SHALL have port out_data  output  2*DW: {I, Q} of current channel.
REQ-012 SHALL have port out_chan  output  2: channel index of out_data.
REQ-013 SHALL have port out_last  output  1: high on last enabled channel of a sample set.
REQ-014 SHALL have port overrun  output  1: sticky, set on any per-channel overwrite.
REQ-015 SHALL have port overrun_count  output  16: saturating count of overwrites.
REQ-016 SHALL have port overrun_clr  input  1: synchronous clear of overrun and overrun_count.

Function
REQ-017 SHALL hold one-deep buffer (I, Q, pending) per channel; rx_strobe[k] with rx_enable_latched[k] loads buffer k and sets pending[k].
REQ-018 SHALL ignore rx_strobe[k] when channel k disabled in latched mask; pending[k] stays 0.
REQ-019 SHALL treat rx_strobe[k] while pending[k]=1 and channel k not being handed off this cycle as overwrite: load new data, set overrun, increment overrun_count (saturate at 0xFFFF).
REQ-020 SHALL, on rx_strobe[k] in same cycle as handoff of channel k, load new data, keep pending[k]=1, no overrun.
REQ-021 SHALL implement FSM states IDLE and SEND.
REQ-022 IDLE: latch rx_enable each cycle; when latched mask nonzero and all enabled channels pending, go to SEND with index = lowest enabled channel.
REQ-023 SHALL assert out_valid the cycle after the all-pending condition is registered (1-cycle latency); out_valid low in IDLE.
REQ-024 SEND: present buffer of index; hold out_data/out_chan/out_last stable while out_valid and not out_ready.
REQ-025 SEND: on out_valid and out_ready, clear pending[index] (unless REQ-020), advance index to next higher enabled channel, skipping disabled ones; no bubble between channels.
REQ-026 SHALL assert out_last when index is highest enabled channel; its handoff returns FSM to IDLE.
REQ-027 SHALL emit channels strictly ascending within a set; out_chan width 2, upper bits 0 when NRX<4.
REQ-028 SHALL ignore rx_enable changes during SEND; new mask takes effect on return to IDLE.
REQ-029 SHALL, with latched mask zero, stay in IDLE and never assert out_valid.
REQ-030 overrun_clr SHALL take priority over a same-cycle overwrite increment (result 0, overrun 0).

Reset
REQ-031 reset_n low SHALL asynchronously force: FSM IDLE, out_valid 0, out_data 0, out_chan 0, out_last 0, pending all 0, buffers 0, overrun 0, overrun_count 0, latched mask 0.
REQ-032 reset_n asserted mid-SEND SHALL abort the set; no partial set is resumed after release.
REQ-033 After reset_n release, first mask latch SHALL occur on the first clock edge; strobes on that edge are ignored.

Verification
REQ-034 NRX=2, mask 2'b11, strobe both with I0=0x000001,Q0=0x000002,I1=0x000003,Q1=0x000004, out_ready=1 -> out_valid 1 cycle later; out_data 0x000001000002 chan 0 last 0, then 0x000003000004 chan 1 last 1, then IDLE.
REQ-035 mask 2'b10 -> only chan 1 emitted, out_last=1 on it; strobes on chan 0 produce nothing and no overrun.
REQ-036 out_ready held 0 for 5 cycles during SEND -> outputs stable all 5 cycles; second strobe on chan 1 in that window -> overrun=1, overrun_count=1, newest chan 1 data emitted.
REQ-037 65537 overwrites then overrun_clr with simultaneous overwrite -> count saturates at 0xFFFF, then reads 0, overrun 0.
REQ-038 reset_n pulsed low during SEND after chan 0 handoff -> outputs 0 immediately; chan 1 never emitted; normal operation on next full set.
REQ-039 mask changed 2'b11->2'b01 during SEND -> current set completes on both channels; following sets chan 0 only with out_last=1.
